pc_branch_ctrl: RTL and testbench

Program-counter and branch-resolution stage that sits directly downstream of the ALU. It latches the ALU's equals/less-than flags into a flag register and resolves conditional and unconditional PC-relative branches against them. It sequences the PC through a start/run/halt life cycle and counts executed cycles for the test harness. Its PC output feeds the instruction ROM; its flag outputs are also exported for debug.

---
 rtl/pc_branch_ctrl.sv | 146 ++++++++++++++
 tb/tb_pc_branch_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_ctrl.sv
// Program counter and branch resolution stage behind the ALU: IDLE/RUN/HALTED sequencing, flag register, PC-relative branches.
// Latency: PC, flags, Running, Done and CycleCount are registered (one edge); Taken is combinational.
// Backpressure: none; one instruction per cycle while in RUN. Optional macro PC_FLAG_FWD_EN forwards ALU flags into Taken.
module pc_branch_ctrl #(
    parameter int          PC_W       = 10,
    parameter int unsigned START_ADDR = 0,
    parameter int          CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Halt,
    input  logic             FlagWrite,
    input  logic             ALU_EQUALS,
    input  logic             ALU_LT,
    input  logic [1:0]       BrCond,
    input  logic [7:0]       BrOffset,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic             Taken,
    output logic             FlagEQ,
    output logic             FlagLT,
    output logic [CNT_W-1:0] CycleCount
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [PC_W-1:0]  START_PC = START_ADDR[PC_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_LT   = 2'b10;
    localparam logic [1:0] BR_ALW  = 2'b11;

    logic [1:0]       state;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_next;
    logic [PC_W-1:0]  off_ext;
    logic [CNT_W-1:0] cnt_q;
    logic             flag_eq;
    logic             flag_lt;
    logic             done_q;
    logic             running;
    logic             taken;
    logic             eq_sel;
    logic             lt_sel;

    assign running = (state == ST_RUN);
    assign off_ext = PC_W'($signed(BrOffset));

`ifdef PC_FLAG_FWD_EN
    // A compare writing the flags in the same cycle as the branch is seen immediately.
    assign eq_sel = FlagWrite ? ALU_EQUALS : flag_eq;
    assign lt_sel = FlagWrite ? ALU_LT     : flag_lt;
`else
    // Branches always see the registered flags; a compare needs one instruction of separation.
    assign eq_sel = flag_eq;
    assign lt_sel = flag_lt;
`endif

    // Resolve the branch condition; only meaningful while executing.
    always_comb begin
        taken = 1'b0;
        case (BrCond)
            BR_NONE: taken = 1'b0;
            BR_EQ:   taken = eq_sel;
            BR_LT:   taken = lt_sel;
            BR_ALW:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        taken = taken & running;
    end

    // Next sequential PC: relative target when taken, otherwise fall through; wraps at 2^PC_W.
    always_comb begin
        pc_next = pc_q + PC_W'(1);
        if (taken) begin
            pc_next = pc_q + off_ext;
        end
    end

    // Life-cycle sequencing, PC, cycle counter and the halt pulse.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= ST_IDLE;
            pc_q   <= START_PC;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (Start) begin
                        state <= ST_RUN;
                        pc_q  <= START_PC;
                        cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (Halt) begin
                        state  <= ST_HALTED;
                        done_q <= 1'b1;
                    end else begin
                        pc_q <= pc_next;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    pc_q  <= START_PC;
                end
            endcase
        end
    end

    // Flag register: written only while executing, cleared on every Start.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            flag_eq <= 1'b0;
            flag_lt <= 1'b0;
        end else if (running) begin
            if (FlagWrite) begin
                flag_eq <= ALU_EQUALS;
                flag_lt <= ALU_LT;
            end
        end else if (Start) begin
            flag_eq <= 1'b0;
            flag_lt <= 1'b0;
        end
    end

    assign PC         = pc_q;
    assign Running    = running;
    assign Done       = done_q;
    assign Taken      = taken;
    assign FlagEQ     = flag_eq;
    assign FlagLT     = flag_lt;
    assign CycleCount = cnt_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Bench for pc_branch_ctrl: directed vector table, hand-written reset/saturation sequences, random run vs reference model.
// Inputs change one time unit after the rising edge; outputs are sampled there too.
// The DUT is built with a small counter width so saturation is reachable quickly.
module tb_pc_branch_ctrl;

    localparam int PC_W    = 10;
    localparam int CNT_W   = 6;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PC_FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             Reset_n;
    logic             Start, Halt, FlagWrite, ALU_EQUALS, ALU_LT;
    logic [1:0]       BrCond;
    logic [7:0]       BrOffset;
    logic [PC_W-1:0]  PC;
    logic             Running, Done, Taken, FlagEQ, FlagLT;
    logic [CNT_W-1:0] CycleCount;

    pc_branch_ctrl #(.PC_W(PC_W), .START_ADDR(0), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Halt(Halt), .FlagWrite(FlagWrite),
        .ALU_EQUALS(ALU_EQUALS), .ALU_LT(ALU_LT), .BrCond(BrCond), .BrOffset(BrOffset),
        .PC(PC), .Running(Running), .Done(Done), .Taken(Taken), .FlagEQ(FlagEQ),
        .FlagLT(FlagLT), .CycleCount(CycleCount)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain architectural state.
    bit m_run, m_done, m_eq, m_lt;
    int m_pc, m_cnt;

    typedef struct {
        bit       start, halt, fw, eq, lt;
        bit [1:0] brc;
        bit [7:0] off;
        bit       exp_taken;
        int       exp_pc;
        bit       exp_run, exp_done;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_taken();
        bit e, l;
        e = (FWD && FlagWrite) ? ALU_EQUALS : m_eq;
        l = (FWD && FlagWrite) ? ALU_LT : m_lt;
        if (!m_run) return 1'b0;
        return (BrCond == 2'd3) || (BrCond == 2'd1 && e) || (BrCond == 2'd2 && l);
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_eq = 0; m_lt = 0; m_pc = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit tk;
        tk = model_taken();
        if (!m_run) begin
            m_done = 0;
            if (Start) begin
                m_run = 1; m_pc = 0; m_eq = 0; m_lt = 0; m_cnt = 0;
            end
        end else begin
            m_done = Halt;
            m_cnt  = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (FlagWrite) begin
                m_eq = ALU_EQUALS; m_lt = ALU_LT;
            end
            if (Halt) m_run = 0;
            else if (tk) m_pc = (m_pc + int'($signed(BrOffset)) + PC_MOD) % PC_MOD;
            else m_pc = (m_pc + 1) % PC_MOD;
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_pc"}, int'(PC), m_pc);
        chk({tag, "_running"}, int'(Running), int'(m_run));
        chk({tag, "_done"}, int'(Done), int'(m_done));
        chk({tag, "_flageq"}, int'(FlagEQ), int'(m_eq));
        chk({tag, "_flaglt"}, int'(FlagLT), int'(m_lt));
        chk({tag, "_cnt"}, int'(CycleCount), m_cnt);
    endtask

    // One cycle: inputs are already driven; check Taken, clock, check registered outputs.
    task automatic tick(input string tag);
        #1;
        chk({tag, "_taken"}, int'(Taken), int'(model_taken()));
        model_step();
        @(posedge CLK);
        #1;
        chk_all(tag);
    endtask

    task automatic drive(input bit st, input bit h, input bit fw, input bit eq, input bit lt,
                         input bit [1:0] brc, input bit [7:0] off);
        Start = st; Halt = h; FlagWrite = fw; ALU_EQUALS = eq; ALU_LT = lt;
        BrCond = brc; BrOffset = off;
    endtask

    task automatic add(input bit st, input bit h, input bit fw, input bit eq, input bit lt,
                       input bit [1:0] brc, input bit [7:0] off,
                       input bit tk, input int pc, input bit run, input bit dn);
        vec_t v;
        v.start = st; v.halt = h; v.fw = fw; v.eq = eq; v.lt = lt; v.brc = brc; v.off = off;
        v.exp_taken = tk; v.exp_pc = pc; v.exp_run = run; v.exp_done = dn;
        tbl.push_back(v);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pc17;
        Reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 2'd0, 8'd0);
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk_all("reset");
        chk("reset_taken", int'(Taken), 0);
        Reset_n = 1'b1;

        // Directed table, run from IDLE at PC=0.
        pc17 = FWD ? 10 : 5;
        add(1,0,0,0,0,2'd0,8'd0,          0, 0,    1,0);   // Start
        for (int i = 1; i <= 9; i++)
            add(0,0,0,0,0,2'd0,8'd0,      0, i,    1,0);   // straight-line 1..9
        add(0,0,1,1,0,2'd0,8'd0,          0, 10,   1,0);   // write EQ=1
        add(0,0,0,0,0,2'd1,8'(-3),        1, 7,    1,0);   // beq -3 at 10
        add(0,0,1,0,0,2'd0,8'd0,          0, 8,    1,0);   // write EQ=0
        add(0,0,0,0,0,2'd0,8'd0,          0, 9,    1,0);
        add(0,0,0,0,0,2'd0,8'd0,          0, 10,   1,0);
        add(0,0,0,0,0,2'd1,8'(-3),        0, 11,   1,0);   // beq not taken
        add(0,0,0,0,0,2'd3,8'(-7),        1, 4,    1,0);   // always -> 4
        add(0,0,1,0,1,2'd2,8'd6,          FWD, pc17, 1,0); // same-cycle write + blt
        add(0,0,0,0,0,2'd3,8'(-(pc17+1)), 1, 1023, 1,0);
        add(0,0,0,0,0,2'd0,8'd0,          0, 0,    1,0);   // wrap
        add(0,0,0,0,0,2'd0,8'd0,          0, 1,    1,0);
        add(0,0,0,0,0,2'd0,8'd0,          0, 2,    1,0);
        add(0,0,0,0,0,2'd3,8'(-5),        1, 1021, 1,0);   // negative wrap
        add(0,0,0,0,0,2'd3,8'd23,         1, 20,   1,0);   // positive wrap
        add(0,1,0,0,0,2'd3,8'd5,          1, 20,   0,1);   // halt beats branch
        add(0,0,0,0,0,2'd3,8'd5,          0, 20,   0,0);   // Done drops
        add(1,0,0,0,0,2'd0,8'd0,          0, 0,    1,0);   // restart

        foreach (tbl[k]) begin
            drive(tbl[k].start, tbl[k].halt, tbl[k].fw, tbl[k].eq, tbl[k].lt, tbl[k].brc, tbl[k].off);
            #1;
            chk($sformatf("tbl%0d_taken", k), int'(Taken), int'(tbl[k].exp_taken));
            tick($sformatf("tbl%0d", k));
            chk($sformatf("tbl%0d_pc_exp", k), int'(PC), tbl[k].exp_pc);
            chk($sformatf("tbl%0d_run_exp", k), int'(Running), int'(tbl[k].exp_run));
            chk($sformatf("tbl%0d_done_exp", k), int'(Done), int'(tbl[k].exp_done));
        end
        chk("restart_cnt", int'(CycleCount), 0);
        chk("restart_flaglt", int'(FlagLT), 0);

        // Asynchronous reset in the middle of a run at PC=37.
        drive(0, 0, 1, 1, 1, 2'd0, 8'd0);
        repeat (37) tick("run37");
        chk("pre_reset_pc", int'(PC), 37);
        drive(0, 0, 0, 0, 0, 2'd3, 8'd9);
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset");
        chk("async_reset_taken", int'(Taken), 0);
        @(posedge CLK);
        #1;
        chk("reset_no_done", int'(Done), 0);
        Reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 2'd0, 8'd0);
        tick("idle_hold");

        // Counter saturation.
        drive(1, 0, 0, 0, 0, 2'd0, 8'd0);
        tick("sat_start");
        drive(0, 0, 0, 0, 0, 2'd0, 8'd0);
        repeat (CNT_MAX + 7) tick("sat");
        chk("cnt_saturated", int'(CycleCount), CNT_MAX);

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
